window_gen_3x3: RTL and testbench
=================================

WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 SHALL have parameter DATA_W, default 8; pixel bit width.
REQ-002 SHALL have parameter IMG_WIDTH, default 64; pixels per row (min 3).
REQ-003 SHALL have parameter IMG_HEIGHT, default 64; rows per frame (min 3).
REQ-004 SHALL use one clock and an asynchronous, active-high reset, as already decided.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous reset, active-high.
REQ-007 sof  input  1  start of frame; qualifies the pixel presented this cycle as (0,0).
REQ-008 pix_in  input  DATA_W  raster-order input pixel.
REQ-009 pix_valid  input  1  pix_in valid this cycle; no backpressure.
REQ-010 p1..p9  output  DATA_W each  3x3 window, row-major; p1 top-left, p5 centre, p9 bottom-right (newest pixel).
REQ-011 win_valid  output  1  p1..p9 hold a complete interior window this cycle.
REQ-012 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-013 SHALL implement the FSM IDLE -> RUN -> DONE -> (sof) RUN.
- IDLE/DONE: pixels ignored unless sof=1 and pix_valid=1.
- On that event: go to RUN, treat the pixel as (0,0).
REQ-014 SHALL accept a pixel only when pix_valid=1 in RUN, or when sof=1 and pix_valid=1 in any state.
REQ-015 SHALL, in RUN, restart at (0,0) when sof=1 and pix_valid=1; the partial frame is abandoned and frame_done is not pulsed.
REQ-016 SHALL keep col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) counters, updated on each accepted pixel.
- col wraps to 0 and increments row.
- After (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted: FSM -> DONE, frame_done=1 on the next cycle.
REQ-017 SHALL keep two line buffers of IMG_WIDTH entries, lb0 (row r-1) and lb1 (row r-2), indexed by col.
- On accepting (r,c): lb1[c] <= lb0[c], lb0[c] <= pix_in.
REQ-018 SHALL shift the window left by one column on each accepted pixel.
- New right column {p3,p6,p9} <= {lb1[c], lb0[c], pix_in}, using line-buffer values read before the update.
REQ-019 SHALL hold p1..p9 unchanged on cycles with no accepted pixel; win_valid=0 on such cycles.
REQ-020 SHALL register win_valid <= accepted AND r>=2 AND c>=2; latency is 1 cycle from acceptance.
- The window is centred on (r-1, c-1).
REQ-021 SHALL not produce border windows and SHALL not pad the image.
- Windows spanning a row wrap (c<2) are never flagged valid.
REQ-022 SHALL not clear line-buffer contents at row wrap or sof; stale data is masked by REQ-020.
REQ-023 SHALL produce exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) win_valid pulses per complete frame.

Reset
REQ-024 SHALL, while rst=1, force:
- FSM=IDLE, row=0, col=0;
- p1..p9=0, win_valid=0, frame_done=0.
REQ-025 SHALL not require reset of line-buffer storage.
REQ-026 SHALL, on reset asserted mid-frame, discard the frame; the next frame starts only with sof.

Structure
REQ-027 SHALL take the DATA_W/IMG_WIDTH/IMG_HEIGHT defaults and the FSM state encodings from the shared image-pipeline package.
REQ-028 SHALL instantiate the sub-module line_buffer twice.
- line_buffer: IMG_WIDTH x DATA_W, synchronous write, same-cycle read at col, no reset.
REQ-029 SHALL keep the window registers and counters in window_gen_3x3.
REQ-030 p1..p9 SHALL connect directly to the downstream filter stage's p1..p9 inputs.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, pixel=(r<<4)|c)
REQ-031 SHALL check the full frame with pix_valid always 1:
- first win_valid one cycle after accepting (2,2);
- that window is p1..p9 = 00,01,02,10,11,12,20,21,22;
- 24 windows total;
- frame_done one cycle after accepting (5,7).
REQ-032 SHALL check random pix_valid gaps: identical window sequence to REQ-031, and p1..p9 held during gaps.
REQ-033 SHALL check the row boundary:
- after window (2,7) = 05,06,07,15,16,17,25,26,27, pixels (3,0) and (3,1) produce no win_valid;
- next window is 10,11,12,20,21,22,30,31,32.
REQ-034 SHALL check pixels without sof after DONE: ignored; a second frame started with sof repeats the REQ-031 results.
REQ-035 SHALL check sof at (3,4) mid-frame: restart at (0,0); no window until (2,2) of the new frame; no frame_done for the old frame.
REQ-036 SHALL check rst asserted mid-frame: all outputs 0 immediately (asynchronously); pixels ignored until sof.

Source files
------------

// File: rtl/window_gen_3x3_pkg.sv
// -----------------------------------------------------------------------------
// window_gen_3x3_pkg
// Shared image-pipeline definitions used by the 3x3 window generator and its
// line buffers: default pixel width and frame geometry, window size, the
// frame-sequencing FSM state encoding, and a counter-width helper.
// -----------------------------------------------------------------------------
package window_gen_3x3_pkg;

    // Default pixel width and frame geometry for the pipeline.
    localparam int DATA_W_DEF     = 8;
    localparam int IMG_WIDTH_DEF  = 64;
    localparam int IMG_HEIGHT_DEF = 64;

    // Window is WIN_SIZE x WIN_SIZE pixels.
    localparam int WIN_SIZE = 3;

    // Frame sequencing: IDLE until the first sof, RUN while a frame streams
    // in, DONE after the last pixel until the next sof.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } win_state_t;

    // Bits needed to hold a counter running 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// One image row of pixel storage, indexed by column.
//   clk     : rising-edge clock for the write port
//   wr_en   : write wr_data to entry addr at the clock edge
//   addr    : column index, shared by the read and write port
//   wr_data : pixel to store
//   rd_data : current contents of entry addr (same-cycle read, i.e. the value
//             stored before any write happening at this edge)
// Storage is deliberately not reset; stale contents are masked by the
// window-valid logic in the consumer.
// -----------------------------------------------------------------------------
module line_buffer
    import window_gen_3x3_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = IMG_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [cnt_width(DEPTH)-1:0]  addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic [DATA_W-1:0]            rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    // Asynchronous read: the window needs the old row values in the same
    // cycle the new pixel is accepted.
    assign rd_data = mem[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// -----------------------------------------------------------------------------
// window_gen_3x3
// Streams raster-order pixels and produces a sliding 3x3 window over interior
// positions only (no border windows, no padding).
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   sof        : start of frame, marks the pixel presented this cycle as (0,0)
//   pix_in     : raster-order input pixel
//   pix_valid  : pix_in valid this cycle (no backpressure)
//   p1..p9     : window, row-major; p1 top-left, p5 centre, p9 newest pixel
//   win_valid  : p1..p9 form a complete interior window this cycle
//   frame_done : one-cycle pulse after the last pixel of a frame is accepted
// The window registers shift left by one column per accepted pixel and hold
// otherwise. Two line buffers supply the rows above the incoming pixel.
// -----------------------------------------------------------------------------
module window_gen_3x3
    import window_gen_3x3_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sof,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic [DATA_W-1:0] p1,
    output logic [DATA_W-1:0] p2,
    output logic [DATA_W-1:0] p3,
    output logic [DATA_W-1:0] p4,
    output logic [DATA_W-1:0] p5,
    output logic [DATA_W-1:0] p6,
    output logic [DATA_W-1:0] p7,
    output logic [DATA_W-1:0] p8,
    output logic [DATA_W-1:0] p9,
    output logic              win_valid,
    output logic              frame_done
);

    localparam int COL_W = cnt_width(IMG_WIDTH);
    localparam int ROW_W = cnt_width(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(WIN_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(WIN_SIZE - 1);

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    win_state_t       state_reg, state_next;
    logic [COL_W-1:0] col_reg, col_next;
    logic [ROW_W-1:0] row_reg, row_next;
    logic             win_valid_reg, win_valid_next;
    logic             frame_done_reg, frame_done_next;

    // Decode of the current cycle
    logic             accept;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             last_pix;

    // ------------------------------------------------------------------
    // FSM output/decode logic: which pixel (if any) is accepted and where
    // it sits in the frame. sof with a valid pixel always wins and forces
    // the pixel to (0,0), whatever the state.
    // ------------------------------------------------------------------
    always_comb begin
        accept          = pix_valid && (sof || (state_reg == ST_RUN));
        cur_col         = sof ? '0 : col_reg;
        cur_row         = sof ? '0 : row_reg;
        last_pix        = accept && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        // Only positions whose full 3x3 neighbourhood lies in this row band
        // produce a window; c<2 would straddle a row wrap.
        win_valid_next  = accept && (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);
        frame_done_next = last_pix;
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (accept) begin
            state_next = last_pix ? ST_DONE : ST_RUN;
        end
    end

    // Raster position counters: point at the position of the next pixel.
    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_next = '0;
                row_next = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_next = cur_col + COL_W'(1);
                row_next = cur_row;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM state register plus counters and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            col_reg        <= '0;
            row_reg        <= '0;
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            col_reg        <= col_next;
            row_reg        <= row_next;
            win_valid_reg  <= win_valid_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign win_valid  = win_valid_reg;
    assign frame_done = frame_done_reg;

    // ------------------------------------------------------------------
    // Line buffers: index 0 holds row r-1, index 1 holds row r-2.
    // On acceptance the old row r-1 value migrates into the r-2 buffer and
    // the new pixel becomes the r-1 value for the next row.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] lb_rd_data [2];
    logic [DATA_W-1:0] lb_wr_data [2];

    always_comb begin
        lb_wr_data[0] = pix_in;
        lb_wr_data[1] = lb_rd_data[0];
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lb
            line_buffer #(
                .DATA_W (DATA_W),
                .DEPTH  (IMG_WIDTH)
            ) u_line_buffer (
                .clk     (clk),
                .wr_en   (accept),
                .addr    (cur_col),
                .wr_data (lb_wr_data[gi]),
                .rd_data (lb_rd_data[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Window registers: one shift row per window row. The new right-hand
    // column is {row r-2, row r-1, row r} at column c, read from the line
    // buffers before this edge's write.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] col_in [WIN_SIZE];

    always_comb begin
        col_in[0] = lb_rd_data[1];
        col_in[1] = lb_rd_data[0];
        col_in[2] = pix_in;
    end

    generate
        for (genvar gi = 0; gi < WIN_SIZE; gi++) begin : g_row
            logic [DATA_W-1:0] taps_reg [WIN_SIZE];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < WIN_SIZE; k++) begin
                        taps_reg[k] <= '0;
                    end
                end else if (accept) begin
                    for (int k = 0; k < WIN_SIZE - 1; k++) begin
                        taps_reg[k] <= taps_reg[k + 1];
                    end
                    taps_reg[WIN_SIZE - 1] <= col_in[gi];
                end
            end
        end
    endgenerate

    assign p1 = g_row[0].taps_reg[0];
    assign p2 = g_row[0].taps_reg[1];
    assign p3 = g_row[0].taps_reg[2];
    assign p4 = g_row[1].taps_reg[0];
    assign p5 = g_row[1].taps_reg[1];
    assign p6 = g_row[1].taps_reg[2];
    assign p7 = g_row[2].taps_reg[0];
    assign p8 = g_row[2].taps_reg[1];
    assign p9 = g_row[2].taps_reg[2];

endmodule

// File: tb/tb_window_gen_3x3.sv
// -----------------------------------------------------------------------------
// tb_window_gen_3x3
// Self-checking bench for window_gen_3x3 with an 8x6 frame. A reference model
// keeps the accepted frame as a 2D image and derives each expected window
// directly from the image neighbourhood of the accepted pixel.
// -----------------------------------------------------------------------------
module tb_window_gen_3x3;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sof;
    logic          pix_valid;
    logic [DW-1:0] pix_in;
    logic [DW-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic          win_valid;
    logic          frame_done;

    always #5 clk = ~clk;

    window_gen_3x3 #(
        .DATA_W     (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sof        (sof),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .p4         (p4),
        .p5         (p5),
        .p6         (p6),
        .p7         (p7),
        .p8         (p8),
        .p9         (p9),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    int tests       = 0;
    int fails       = 0;
    int obs_windows = 0;
    int cyc         = 0;

    // Reference model state
    bit            m_in_frame;
    int            m_r, m_c;
    logic [DW-1:0] img [H][W];
    bit            m_known;   // model knows what p1..p9 must hold
    logic [71:0]   m_win;

    typedef struct {
        int          r;
        int          c;
        bit          wv;
        bit          fd;
        logic [71:0] p;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [71:0] obs_win();
        return {p1, p2, p3, p4, p5, p6, p7, p8, p9};
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_r        = 0;
        m_c        = 0;
        m_known    = 1'b1;
        m_win      = '0;
    endtask

    // One clock of stimulus followed by a check of the registered outputs.
    task automatic cycle(input bit s, input bit v, input logic [DW-1:0] px);
        bit acc;
        bit exp_wv;
        bit exp_fd;
        @(negedge clk);
        sof       = s;
        pix_valid = v;
        pix_in    = px;
        acc    = v && (s || m_in_frame);
        exp_wv = 1'b0;
        exp_fd = 1'b0;
        if (acc) begin
            if (s) begin
                m_r        = 0;
                m_c        = 0;
                m_in_frame = 1'b1;
            end
            img[m_r][m_c] = px;
            if (m_r >= 2 && m_c >= 2) begin
                exp_wv  = 1'b1;
                m_known = 1'b1;
                for (int k = 0; k < 9; k++) begin
                    m_win[71 - 8*k -: 8] = img[m_r - 2 + k/3][m_c - 2 + k%3];
                end
            end else begin
                m_known = 1'b0;
            end
            if (m_r == H-1 && m_c == W-1) begin
                exp_fd     = 1'b1;
                m_in_frame = 1'b0;
            end
            m_c++;
            if (m_c == W) begin
                m_c = 0;
                m_r++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        $display("[TB] cyc %0d sof=%0b v=%0b pix=%02h -> wv=%0b fd=%0b win=%h",
                 cyc, s, v, px, win_valid, frame_done, obs_win());
        if (win_valid === 1'b1) obs_windows++;
        check("win_valid", {71'd0, win_valid}, {71'd0, exp_wv});
        check("frame_done", {71'd0, frame_done}, {71'd0, exp_fd});
        if (m_known) check("window", obs_win(), m_win);
    endtask

    task automatic send_frame(input int gap_mod, input bit rnd_pix);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int g;
                g = 0;
                if (gap_mod > 0 && $urandom_range(0, gap_mod - 1) == 0) g = $urandom_range(1, 3);
                repeat (g) cycle(1'b0, 1'b0, 8'($urandom));
                cycle((r == 0 && c == 0), 1'b1,
                      rnd_pix ? 8'($urandom) : 8'((r << 4) | c));
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_wv"}, {71'd0, win_valid}, 72'd0);
        check({name, "_fd"}, {71'd0, frame_done}, 72'd0);
        check({name, "_win"}, obs_win(), 72'd0);
    endtask

    initial begin
        tbl[0] = '{r: 1, c: 7, wv: 1'b0, fd: 1'b0, p: 72'h0};
        tbl[1] = '{r: 2, c: 1, wv: 1'b0, fd: 1'b0, p: 72'h0};
        tbl[2] = '{r: 2, c: 2, wv: 1'b1, fd: 1'b0, p: 72'h000102_101112_202122};
        tbl[3] = '{r: 2, c: 7, wv: 1'b1, fd: 1'b0, p: 72'h050607_151617_252627};
        tbl[4] = '{r: 3, c: 0, wv: 1'b0, fd: 1'b0, p: 72'h0};
        tbl[5] = '{r: 3, c: 1, wv: 1'b0, fd: 1'b0, p: 72'h0};
        tbl[6] = '{r: 3, c: 2, wv: 1'b1, fd: 1'b0, p: 72'h101112_202122_303132};
        tbl[7] = '{r: 5, c: 7, wv: 1'b1, fd: 1'b1, p: 72'h353637_454647_555657};

        // Power-on reset
        rst       = 1'b1;
        sof       = 1'b0;
        pix_valid = 1'b0;
        pix_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Frame 1: continuous pixels, table-driven checkpoints
        begin
            int idx;
            idx         = 0;
            obs_windows = 0;
            for (int t = 0; t < 8; t++) begin
                while (idx <= tbl[t].r * W + tbl[t].c) begin
                    cycle(idx == 0, 1'b1, 8'(((idx / W) << 4) | (idx % W)));
                    idx++;
                end
                check("tbl_wv", {71'd0, win_valid}, {71'd0, tbl[t].wv});
                check("tbl_fd", {71'd0, frame_done}, {71'd0, tbl[t].fd});
                if (tbl[t].wv) check("tbl_win", obs_win(), tbl[t].p);
            end
            check("frame1_windows", 72'(obs_windows), 72'd24);
        end

        // Pixels without sof after DONE are ignored, window held
        repeat (6) cycle(1'b0, 1'b1, 8'hAA);
        cycle(1'b0, 1'b0, 8'h55);

        // Frame 2: same pattern with random valid gaps
        obs_windows = 0;
        send_frame(3, 1'b0);
        check("frame2_windows", 72'(obs_windows), 72'd24);

        // Frame 3: sof arrives at (3,4), abandoning the partial frame
        obs_windows = 0;
        for (int i = 0; i < 3 * W + 4; i++) begin
            cycle(i == 0, 1'b1, 8'(((i / W) << 4) | (i % W)));
        end
        check("partial_windows", 72'(obs_windows), 72'd8);
        obs_windows = 0;
        send_frame(0, 1'b0);
        check("restart_windows", 72'(obs_windows), 72'd24);

        // Reset mid-frame: outputs clear asynchronously, frame discarded
        for (int i = 0; i < 2 * W + 6; i++) begin
            cycle(i == 0, 1'b1, 8'($urandom));
        end
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        sof       = 1'b1;
        pix_valid = 1'b1;
        pix_in    = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst_held");
        @(negedge clk);
        sof       = 1'b0;
        pix_valid = 1'b0;
        rst       = 1'b0;
        model_reset();
        repeat (5) cycle(1'b0, 1'b1, 8'($urandom));
        obs_windows = 0;
        send_frame(4, 1'b1);
        check("post_rst_windows", 72'(obs_windows), 72'd24);

        // Randomized stream: random gaps, random sof (rare mid-frame)
        repeat (500) begin
            bit v;
            bit s;
            v = ($urandom_range(0, 3) != 0);
            s = m_in_frame ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 3) == 0);
            cycle(s, v, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
